// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sync_debounce
// Function : Multi-channel flop synchroniser + stability filter with edge pulses
// Revision : 1.0
// ============================================================================
module sync_debounce #(
    parameter int                    DATA_WIDTH  = 1,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    FILTER_LEN  = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [DATA_WIDTH-1:0] rise_o,
    output logic [DATA_WIDTH-1:0] fall_o,
    output logic                  change_o
);

    // A one-cycle filter still needs a 1-bit counter to stay legal.
    localparam int                 c_cnt_w   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILTER_LEN - 1);

    generate
        if (SYNC_STAGES < 2) begin : g_chk_sync
            $error("sync_debounce: SYNC_STAGES must be >= 2");
        end
        if (FILTER_LEN < 1) begin : g_chk_filt
            $error("sync_debounce: FILTER_LEN must be >= 1");
        end
        if (DATA_WIDTH < 1) begin : g_chk_width
            $error("sync_debounce: DATA_WIDTH must be >= 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [c_cnt_w-1:0]    r_cnt  [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_rise;
    logic [DATA_WIDTH-1:0] r_fall;
    logic                  r_change;

    logic [DATA_WIDTH-1:0] w_sync_q;
    logic [DATA_WIDTH-1:0] w_differ;
    logic [DATA_WIDTH-1:0] w_update;

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    // Pure flop chain: nothing may sit between stages.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= RESET_VALUE;
            end
        end else begin
            r_sync[0] <= data_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    always_comb begin
        w_differ = w_sync_q ^ r_data;
        w_update = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_update[i] = w_differ[i] && (r_cnt[i] == c_cnt_max);
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
            r_data   <= RESET_VALUE;
            r_rise   <= '0;
            r_fall   <= '0;
            r_change <= 1'b0;
        end else begin
            // Any agreement clears the count, so a bounce restarts filtering.
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (!w_differ[i] || w_update[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_w'(1);
                end
            end
            r_data   <= (r_data & ~w_update) | (w_sync_q & w_update);
            r_rise   <= w_update & w_sync_q;
            r_fall   <= w_update & ~w_sync_q;
            r_change <= |(r_rise | r_fall);
        end
    end

    assign data_o   = r_data;
    assign rise_o   = r_rise;
    assign fall_o   = r_fall;
    assign change_o = r_change;

endmodule
`default_nettype wire

// File: tb/tb_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_debounce
// Function : Directed self-checking bench for sync_debounce (three configurations)
// Revision : 1.0
// ============================================================================
module tb_sync_debounce;

    logic clk;
    logic arstn_a, arstn_b, arstn_c;
    logic       data_a;
    logic [3:0] data_b, data_c;

    logic       a_data, a_rise, a_fall, a_chg;
    logic [3:0] b_data, b_rise, b_fall;
    logic       b_chg;
    logic [3:0] c_data, c_rise, c_fall;
    logic       c_chg;

    int n_checks = 0;
    int n_errors = 0;

    sync_debounce dut_a (
        .clk_i   (clk),
        .arstn_i (arstn_a),
        .data_i  (data_a),
        .data_o  (a_data),
        .rise_o  (a_rise),
        .fall_o  (a_fall),
        .change_o(a_chg)
    );

    sync_debounce #(.DATA_WIDTH(4)) dut_b (
        .clk_i   (clk),
        .arstn_i (arstn_b),
        .data_i  (data_b),
        .data_o  (b_data),
        .rise_o  (b_rise),
        .fall_o  (b_fall),
        .change_o(b_chg)
    );

    sync_debounce #(
        .DATA_WIDTH (4),
        .SYNC_STAGES(3),
        .FILTER_LEN (1),
        .RESET_VALUE(4'hF)
    ) dut_c (
        .clk_i   (clk),
        .arstn_i (arstn_c),
        .data_i  (data_c),
        .data_o  (c_data),
        .rise_o  (c_rise),
        .fall_o  (c_fall),
        .change_o(c_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit k of each vector: input before edge k+1 / expected output after edge k+1.
    task automatic run_a(input string name, input logic [15:0] pat, input int edges,
                         input logic [15:0] e_data, input logic [15:0] e_rise,
                         input logic [15:0] e_fall, input logic [15:0] e_chg);
        for (int k = 0; k < edges; k++) begin
            data_a = pat[k];
            tick();
            check_value($sformatf("%s data e%0d", name, k+1), 32'(a_data), 32'(e_data[k]));
            check_value($sformatf("%s rise e%0d", name, k+1), 32'(a_rise), 32'(e_rise[k]));
            check_value($sformatf("%s fall e%0d", name, k+1), 32'(a_fall), 32'(e_fall[k]));
            check_value($sformatf("%s chg e%0d",  name, k+1), 32'(a_chg),  32'(e_chg[k]));
        end
    endtask

    initial begin
        arstn_a = 1'b0; arstn_b = 1'b0; arstn_c = 1'b0;
        data_a  = 1'b1; data_b  = 4'h0; data_c  = 4'hF;

        // 1: reset held with input high, then release and mid-cycle re-assert
        for (int k = 0; k < 3; k++) begin
            tick();
            check_value("rst data", 32'(a_data), 32'h0);
            check_value("rst rise", 32'(a_rise), 32'h0);
            check_value("rst fall", 32'(a_fall), 32'h0);
            check_value("rst c data", 32'(c_data), 32'hF);
        end
        arstn_a = 1'b1;
        run_a("rel", 16'hFFFF, 7, 16'h0060, 16'h0020, 16'h0000, 16'h0040);
        #2;
        arstn_a = 1'b0;
        #1;
        check_value("async rst data", 32'(a_data), 32'h0);
        data_a = 1'b0;
        tick();
        arstn_a = 1'b1;

        // 2: clean rise then clean fall
        run_a("rise", 16'hFFFF, 8, 16'h00E0, 16'h0020, 16'h0000, 16'h0040);
        run_a("fall", 16'h0000, 8, 16'h001F, 16'h0000, 16'h0020, 16'h0040);

        // 3: glitch shorter than the filter, then exactly filter length
        run_a("gl3", 16'h0007, 12, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        run_a("gl4", 16'h000F, 12, 16'h01E0, 16'h0020, 16'h0200, 16'h0440);

        // 4: bounce 1,1,0,1,1,1,0,1 then steady high
        run_a("bounce", 16'hFFBB, 16, 16'hF000, 16'h1000, 16'h0000, 16'h2000);

        // 5: four channels
        arstn_b = 1'b1;
        data_b = 4'b0101;
        tick(); tick();
        data_b = 4'b0001;
        tick(); tick(); tick();
        check_value("mc e5 data", 32'(b_data), 32'h0);
        tick();
        check_value("mc e6 data", 32'(b_data), 32'h1);
        check_value("mc e6 rise", 32'(b_rise), 32'h1);
        check_value("mc e6 fall", 32'(b_fall), 32'h0);
        tick();
        check_value("mc e7 rise", 32'(b_rise), 32'h0);
        check_value("mc e7 chg",  32'(b_chg),  32'h1);
        data_b = 4'b1011;
        for (int k = 0; k < 6; k++) tick();
        check_value("mc up rise", 32'(b_rise), 32'hA);
        check_value("mc up data", 32'(b_data), 32'hB);
        for (int k = 0; k < 4; k++) tick();
        data_b = 4'b0001;
        for (int k = 0; k < 5; k++) tick();
        check_value("mc dn e5 fall", 32'(b_fall), 32'h0);
        tick();
        check_value("mc dn e6 fall", 32'(b_fall), 32'hA);
        check_value("mc dn e6 rise", 32'(b_rise), 32'h0);
        check_value("mc dn e6 data", 32'(b_data), 32'h1);
        tick();
        check_value("mc dn e7 chg",  32'(b_chg),  32'h1);
        check_value("mc dn e7 fall", 32'(b_fall), 32'h0);
        tick();
        check_value("mc dn e8 chg",  32'(b_chg),  32'h0);

        // 6: FILTER_LEN=1, SYNC_STAGES=3, reset value all ones
        arstn_c = 1'b1;
        tick(); tick();
        check_value("f1 idle data", 32'(c_data), 32'hF);
        check_value("f1 idle fall", 32'(c_fall), 32'h0);
        data_c = 4'h0;
        tick(); tick(); tick();
        check_value("f1 e3 data", 32'(c_data), 32'hF);
        tick();
        check_value("f1 e4 data", 32'(c_data), 32'h0);
        check_value("f1 e4 fall", 32'(c_fall), 32'hF);
        tick();
        check_value("f1 e5 fall", 32'(c_fall), 32'h0);
        check_value("f1 e5 chg",  32'(c_chg),  32'h1);
        tick(); tick();
        data_c = 4'h1;
        tick();
        data_c = 4'h0;
        tick(); tick();
        check_value("f1 p e3 data", 32'(c_data), 32'h0);
        tick();
        check_value("f1 p e4 data", 32'(c_data), 32'h1);
        check_value("f1 p e4 rise", 32'(c_rise), 32'h1);
        tick();
        check_value("f1 p e5 data", 32'(c_data), 32'h0);
        check_value("f1 p e5 fall", 32'(c_fall), 32'h1);
        check_value("f1 p e5 rise", 32'(c_rise), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Multi-channel clock-domain-crossing input conditioner for asynchronous pins (e.g. SPI CS_N, SCLK, external strobes).
- Each channel passes through a parametrised flop synchroniser and a per-channel stability (debounce) filter.
- Each channel produces a filtered level plus single-cycle rise and fall pulses.
- Sits directly behind the pad inputs; all downstream logic consumes data_o, rise_o and fall_o in the clk_i domain.

Parameters:
- DATA_WIDTH, 1, number of independent channels.
- SYNC_STAGES, 2, synchroniser flop depth per channel; must be >= 2.
- FILTER_LEN, 4, consecutive cycles the synchronised value must differ from data_o before data_o updates; must be >= 1 (1 = no filtering).
- RESET_VALUE, '0, DATA_WIDTH-bit per-channel value loaded into every synchroniser stage and into data_o on reset.

Ports:
- clk_i  input  1  destination-domain clock
- arstn_i  input  1  reset, asynchronous, active-low
- data_i  input  DATA_WIDTH  asynchronous raw inputs
- data_o  output  DATA_WIDTH  synchronised, filtered level
- rise_o  output  DATA_WIDTH  one-cycle pulse per channel on a filtered 0->1 transition
- fall_o  output  DATA_WIDTH  one-cycle pulse per channel on a filtered 1->0 transition
- change_o  output  1  OR-reduction of (rise_o | fall_o), registered

Behaviour:
- Reset (arstn_i low, asynchronous):
  - all sync stages and data_o = RESET_VALUE.
  - filter counters = 0.
  - rise_o, fall_o, change_o = 0.
  - Takes effect immediately, including mid-filter; in-progress counts are discarded.
- Reset release:
  - No pulse is generated by reset itself.
  - If data_i != RESET_VALUE, the channel sees a normal transition and updates after full latency, with the matching pulse.
- Synchroniser: shift chain of SYNC_STAGES flops per bit. sync_q = last stage. No logic between stages.
- Filter, per channel i, counter width $clog2(FILTER_LEN):
  - sync_q[i] == data_o[i]: cnt <= 0.
  - Else, cnt < FILTER_LEN-1: cnt <= cnt+1.
  - Else (cnt == FILTER_LEN-1): data_o[i] <= sync_q[i], cnt <= 0.
- Glitch rejection:
  - Any return of sync_q to data_o before the count completes clears the counter (no hysteresis memory).
  - Bouncing restarts the count.
- Latency: data_i stable before clock edge 1 -> data_o changes at edge SYNC_STAGES+FILTER_LEN (defaults: edge 6).
- Minimum pulse widths:
  - A data_i pulse of >= FILTER_LEN cycles (as seen at sync_q) propagates.
  - A pulse of < FILTER_LEN cycles is fully suppressed, with no output pulses.
- Edge pulses:
  - Registered on the same edge that updates data_o: rise_o[i] = update & sync_q[i]; fall_o[i] = update & ~sync_q[i].
  - High exactly one cycle, coincident with the first cycle of the new data_o.
  - Never both high on one channel.
- change_o: registered one cycle after the pulses (one-cycle lag); high for one cycle per edge event. Simultaneous edges on several channels produce a single change_o cycle.
- Channels are fully independent; simultaneous events on different channels are each reported in the same cycle.
- Elaboration: $error if SYNC_STAGES < 2, FILTER_LEN < 1, or DATA_WIDTH < 1.

Test Plan:
1. Reset, defaults, DATA_WIDTH=1, RESET_VALUE=0, data_i=1 held during reset:
   - data_o=0, rise_o=0, fall_o=0 throughout reset.
   - After release, data_o=1 at edge 6 with rise_o pulse.
   - Reasserting arstn_i between clock edges drives data_o=0 immediately.
2. Clean edge, defaults, data_i 0->1 before edge 1:
   - data_o=1 from edge 6; rise_o=1 only for cycle 6; change_o=1 only for cycle 7.
   - Then 1->0 gives fall_o at the corresponding edge.
3. Glitch filter, defaults:
   - data_i high 3 cycles -> data_o stays 0, no pulses.
   - data_i high 4 cycles -> data_o high exactly 4 cycles, one rise_o, one fall_o.
4. Bounce: data_i pattern 1,1,0,1,1,1,0,1 then steady 1 -> counter restarts on each 0; single rise_o 4 cycles after sync_q settles.
5. Multi-channel, DATA_WIDTH=4:
   - ch0 clean rise while ch2 glitches for 2 cycles -> rise_o=4'b0001, fall_o=0.
   - ch1 and ch3 falling on the same cycle -> fall_o=4'b1010 and a single change_o cycle.
6. FILTER_LEN=1, SYNC_STAGES=3, RESET_VALUE=4'hF:
   - Reset -> data_o=4'hF.
   - data_i=0 -> data_o=0 at edge 4, fall_o=4'hF for one cycle.
   - A 1-cycle pulse on data_i propagates.
